// File: rtl/bus_arbiter_if.sv
// Request/grant bus between two requesting masters, the arbiter and the single slave.
// The same bundle carries both master-side and slave-side signals of the arbiter.
interface bus_arbiter_if;
  // Handshake: a master raises mX_req with a stable payload and holds both until
  // the single-cycle mX_gnt pulse; the slave answers s_req with a single-cycle
  // s_ack carrying s_rdata; mX_err qualifies mX_gnt when the slave never answered.
  logic [31:0] m0_wdata;
  logic [31:0] m0_addr;
  logic        m0_we;
  logic        m0_re;
  logic [1:0]  m0_hb;
  logic        m0_req;
  logic [31:0] m0_rdata;
  logic        m0_gnt;
  logic        m0_err;

  logic [31:0] m1_wdata;
  logic [31:0] m1_addr;
  logic        m1_we;
  logic        m1_re;
  logic [1:0]  m1_hb;
  logic        m1_req;
  logic [31:0] m1_rdata;
  logic        m1_gnt;
  logic        m1_err;

  logic [31:0] s_wdata;
  logic [31:0] s_addr;
  logic [1:0]  s_hb;
  logic        s_we;
  logic        s_re;
  logic        s_req;
  logic [31:0] s_rdata;
  logic        s_ack;

  // Arbiter view: it serves the masters and drives the slave bus.
  modport slave (
    input  m0_wdata, m0_addr, m0_we, m0_re, m0_hb, m0_req,
    output m0_rdata, m0_gnt, m0_err,
    input  m1_wdata, m1_addr, m1_we, m1_re, m1_hb, m1_req,
    output m1_rdata, m1_gnt, m1_err,
    output s_wdata, s_addr, s_hb, s_we, s_re, s_req,
    input  s_rdata, s_ack
  );

  // Environment view: requesting masters plus the slave device.
  modport master (
    output m0_wdata, m0_addr, m0_we, m0_re, m0_hb, m0_req,
    input  m0_rdata, m0_gnt, m0_err,
    output m1_wdata, m1_addr, m1_we, m1_re, m1_hb, m1_req,
    input  m1_rdata, m1_gnt, m1_err,
    input  s_wdata, s_addr, s_hb, s_we, s_re, s_req,
    output s_rdata, s_ack
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter onto one slave bus, with registered responses
// and a watchdog that completes a transfer with an error if the slave stays silent.
module bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  bus_arbiter_if.slave bus,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          owner;
  logic          owner_nxt;
  logic          last;
  logic          last_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          err_flag;
  logic          err_nxt;
  logic [31:0]   rdata0;
  logic [31:0]   rdata0_nxt;
  logic [31:0]   rdata1;
  logic [31:0]   rdata1_nxt;

  logic          any_req;
  logic          pick;
  logic          expired;
  logic          in_busy;
  logic          in_resp;

  assign any_req = bus.m0_req | bus.m1_req;
  // Both requesting: hand the bus to whoever was not served last.
  assign pick    = (bus.m0_req & bus.m1_req) ? ~last : bus.m1_req;
  assign expired = (cnt == CW'(TIMEOUT - 1));
  assign in_busy = (state == BUSY);
  assign in_resp = (state == RESP);

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    last_nxt   = last;
    cnt_nxt    = cnt;
    err_nxt    = err_flag;
    rdata0_nxt = rdata0;
    rdata1_nxt = rdata1;
    case (state)
      IDLE: begin
        if (any_req) begin
          owner_nxt = pick;
          cnt_nxt   = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // An ACK arriving on the expiry cycle still completes normally.
        if (bus.s_ack) begin
          if (owner) rdata1_nxt = bus.s_rdata;
          else       rdata0_nxt = bus.s_rdata;
          err_nxt   = 1'b0;
          last_nxt  = owner;
          state_nxt = RESP;
        end else if (expired) begin
          if (owner) rdata1_nxt = '0;
          else       rdata0_nxt = '0;
          err_nxt   = 1'b1;
          last_nxt  = owner;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      cnt      <= '0;
      err_flag <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      last     <= last_nxt;
      cnt      <= cnt_nxt;
      err_flag <= err_nxt;
      rdata0   <= rdata0_nxt;
      rdata1   <= rdata1_nxt;
    end
  end

  // Slave bus carries the owner's payload only while BUSY, zero otherwise.
  always_comb begin
    bus.s_req   = 1'b0;
    bus.s_we    = 1'b0;
    bus.s_re    = 1'b0;
    bus.s_hb    = 2'b00;
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    if (in_busy) begin
      bus.s_req = 1'b1;
      if (owner) begin
        bus.s_we    = bus.m1_we;
        bus.s_re    = bus.m1_re;
        bus.s_hb    = bus.m1_hb;
        bus.s_addr  = bus.m1_addr;
        bus.s_wdata = bus.m1_wdata;
      end else begin
        bus.s_we    = bus.m0_we;
        bus.s_re    = bus.m0_re;
        bus.s_hb    = bus.m0_hb;
        bus.s_addr  = bus.m0_addr;
        bus.s_wdata = bus.m0_wdata;
      end
    end
  end

  assign bus.m0_gnt   = in_resp & ~owner;
  assign bus.m1_gnt   = in_resp & owner;
  assign bus.m0_err   = in_resp & ~owner & err_flag;
  assign bus.m1_err   = in_resp & owner & err_flag;
  assign bus.m0_rdata = rdata0;
  assign bus.m1_rdata = rdata1;

  assign dbg_state = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: vector table of single transfers, arbitration and reset
// sequences, and a grant monitor popping an expected-completion queue.
module tb_bus_arbiter;

  localparam int TIMEOUT = 16;
  localparam int W = 34;  // {master, rdata, err}

  typedef struct {
    logic        mst;
    logic        we;
    logic        re;
    logic [1:0]  hb;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_at;   // BUSY cycle (1-based) the slave acks in, 0 = never
    logic [31:0] sdata;
    bit          late_ack;
    bit          drop_req;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_busy;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  bus_arbiter_if bus ();

  bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int          checks;
  int          errors;
  logic [W-1:0] exp_q[$];
  logic [31:0] mdl_rdata [2];
  vec_t        vecs[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic mst, input logic we, input logic re,
                              input logic [1:0] hb, input logic [31:0] addr,
                              input logic [31:0] wdata, input int ack_at,
                              input logic [31:0] sdata, input bit late_ack,
                              input bit drop_req);
    vec_t v;
    v.mst = mst; v.we = we; v.re = re; v.hb = hb; v.addr = addr; v.wdata = wdata;
    v.ack_at = ack_at; v.sdata = sdata; v.late_ack = late_ack; v.drop_req = drop_req;
    v.exp_err   = (ack_at == 0) || (ack_at > TIMEOUT);
    v.exp_rdata = v.exp_err ? 32'h0 : sdata;
    v.exp_busy  = v.exp_err ? TIMEOUT : ack_at;
    return v;
  endfunction

  task automatic clear_masters();
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_re = 0; bus.m0_hb = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_re = 0; bus.m1_hb = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
  endtask

  task automatic drive_master(input vec_t v);
    if (v.mst) begin
      bus.m1_we = v.we; bus.m1_re = v.re; bus.m1_hb = v.hb;
      bus.m1_addr = v.addr; bus.m1_wdata = v.wdata; bus.m1_req = 1'b1;
    end else begin
      bus.m0_we = v.we; bus.m0_re = v.re; bus.m0_hb = v.hb;
      bus.m0_addr = v.addr; bus.m0_wdata = v.wdata; bus.m0_req = 1'b1;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_s_ctl"}, {27'd0, bus.s_hb, bus.s_we, bus.s_re, bus.s_req}, 32'h0);
    check({tag, "_s_addr"}, bus.s_addr, 32'h0);
    check({tag, "_s_wdata"}, bus.s_wdata, 32'h0);
  endtask

  // ---------------- driver: one transfer from the vector table ----------------
  task automatic run_vec(input int idx, input vec_t v);
    int busy;
    bit done;
    @(negedge clk);
    drive_master(v);
    exp_q.push_back({v.mst, v.exp_rdata, v.exp_err});
    busy = 0;
    done = 0;
    for (int c = 0; c < TIMEOUT + 10 && !done; c++) begin
      @(negedge clk);
      bus.s_ack = 1'b0;
      if (bus.s_req) begin
        busy++;
        check($sformatf("v%0d_s_addr", idx), bus.s_addr, v.addr);
        check($sformatf("v%0d_s_wdata", idx), bus.s_wdata, v.wdata);
        check($sformatf("v%0d_s_ctl", idx), {27'd0, bus.s_hb, bus.s_we, bus.s_re, bus.s_req},
              {27'd0, v.hb, v.we, v.re, 1'b1});
        if (v.drop_req && busy == 1) begin
          if (v.mst) bus.m1_req = 1'b0;
          else       bus.m0_req = 1'b0;
        end
        if (busy == v.ack_at) begin
          bus.s_ack   = 1'b1;
          bus.s_rdata = v.sdata;
        end
      end else if (busy > 0) begin
        check_outputs_zero($sformatf("v%0d_resp", idx));
        check($sformatf("v%0d_busy_len", idx), busy, v.exp_busy);
        check($sformatf("v%0d_gnt_timing", idx),
              {31'd0, (v.mst ? bus.m1_gnt : bus.m0_gnt)}, 32'h1);
        if (v.late_ack) begin
          bus.s_ack   = 1'b1;
          bus.s_rdata = 32'hDEAD_BEEF;
        end
        done = 1;
      end
    end
    if (!done) check($sformatf("v%0d_completion", idx), 32'h0, 32'h1);
    @(negedge clk);
    bus.s_ack = 1'b0;
    clear_masters();
    check_outputs_zero($sformatf("v%0d_idle", idx));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic         got_m;
    if (bus.m0_gnt || bus.m1_gnt) begin
      if (exp_q.size() == 0) begin
        check("unexpected_gnt", {30'd0, bus.m1_gnt, bus.m0_gnt}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        got_m = bus.m1_gnt;
        check("gnt_master", {31'd0, got_m}, {31'd0, e[W-1]});
        check("gnt_onehot", {31'd0, bus.m0_gnt & bus.m1_gnt}, 32'h0);
        check("gnt_err", {31'd0, (got_m ? bus.m1_err : bus.m0_err)}, {31'd0, e[0]});
        check("other_err", {31'd0, (got_m ? bus.m0_err : bus.m1_err)}, 32'h0);
        mdl_rdata[e[W-1]] = e[32:1];
        check("m0_rdata", bus.m0_rdata, mdl_rdata[0]);
        check("m1_rdata", bus.m1_rdata, mdl_rdata[1]);
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int k;
    bit seen;
    checks = 0;
    errors = 0;
    mdl_rdata[0] = '0;
    mdl_rdata[1] = '0;
    rst_n = 1'b0;
    bus.s_ack = 1'b0;
    bus.s_rdata = '0;
    clear_masters();

    // reset state
    #1;
    check_outputs_zero("rst");
    check("rst_gnt_err", {28'd0, bus.m1_gnt, bus.m1_err, bus.m0_gnt, bus.m0_err}, 32'h0);
    check("rst_m0_rdata", bus.m0_rdata, 32'h0);
    check("rst_m1_rdata", bus.m1_rdata, 32'h0);
    check("rst_state", {30'd0, dbg_state}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // both masters requesting from reset: M0 first, then strict alternation
    bus.m0_addr = 32'h10; bus.m0_re = 1'b1; bus.m0_hb = 2'b10; bus.m0_req = 1'b1;
    bus.m1_addr = 32'h20; bus.m1_re = 1'b1; bus.m1_hb = 2'b10; bus.m1_req = 1'b1;
    for (int i = 1; i <= 4; i++)
      exp_q.push_back({((i % 2) == 0), 32'hA000_0000 + 32'(i), 1'b0});
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      @(negedge clk);
      bus.s_ack = 1'b0;
      if (bus.s_req) begin
        k++;
        check($sformatf("arb_addr_%0d", k), bus.s_addr, ((k % 2) == 1) ? 32'h10 : 32'h20);
        bus.s_ack   = 1'b1;
        bus.s_rdata = 32'hA000_0000 + 32'(k);
      end
    end
    check("arb_acks", k, 4);
    @(negedge clk);
    bus.s_ack = 1'b0;
    clear_masters();
    repeat (3) @(negedge clk);
    check("arb_drained", exp_q.size(), 0);

    // vector table
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 2'b10, 32'h0000_0100, 32'h0,           1, 32'hCAFE_BABE, 0, 0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 2'b01, 32'h0000_0202, 32'h0000_1234,   1, 32'h0000_5A5A, 0, 0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 2'b10, 32'h0000_0400, 32'h0,     TIMEOUT, 32'h55AA_55AA, 0, 0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 2'b10, 32'h0000_0404, 32'h0,           0, 32'h0,         1, 0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_0013, 32'h0000_00EF,   3, 32'h1111_2222, 0, 0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 2'b10, 32'h8000_0000, 32'h0, TIMEOUT - 1, 32'h3333_4444, 0, 0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_0822, 32'h0,           2, 32'h7777_8888, 0, 1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 2'b10, 32'h0000_0C00, 32'hFFFF_0000,   0, 32'h0,         0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1'($urandom_range(0, 1)), 1'b0, 1'b1, 2'($urandom_range(0, 2)),
                        $urandom, $urandom, int'($urandom_range(0, TIMEOUT + 1)), $urandom, 0, 0));
    for (int i = 0; i < vecs.size(); i++)
      run_vec(i, vecs[i]);
    repeat (2) @(negedge clk);
    check("vec_drained", exp_q.size(), 0);

    // asynchronous reset in the middle of a BUSY transfer
    @(negedge clk);
    bus.m0_addr = 32'h300; bus.m0_re = 1'b1; bus.m0_hb = 2'b10; bus.m0_req = 1'b1;
    for (int c = 0; c < 5 && !bus.s_req; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("pre_rst_busy", {31'd0, bus.s_req}, 32'h1);
    #2;
    rst_n = 1'b0;
    mdl_rdata[0] = '0;
    mdl_rdata[1] = '0;
    bus.m1_addr = 32'h400; bus.m1_re = 1'b1; bus.m1_hb = 2'b10; bus.m1_req = 1'b1;
    #1;
    check_outputs_zero("mid_rst");
    check("mid_rst_gnt_err", {28'd0, bus.m1_gnt, bus.m1_err, bus.m0_gnt, bus.m0_err}, 32'h0);
    check("mid_rst_m0_rdata", bus.m0_rdata, 32'h0);
    check("mid_rst_m1_rdata", bus.m1_rdata, 32'h0);
    check("mid_rst_state", {30'd0, dbg_state}, 32'h0);
    bus.m0_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({1'b1, 32'h1357_9BDF, 1'b0});
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (bus.s_req) begin
        check("post_rst_addr", bus.s_addr, 32'h400);
        bus.s_ack   = 1'b1;
        bus.s_rdata = 32'h1357_9BDF;
        seen = 1;
      end
    end
    check("post_rst_served", {31'd0, seen}, 32'h1);
    @(negedge clk);
    bus.s_ack = 1'b0;
    bus.m1_req = 1'b0;
    repeat (3) @(negedge clk);
    check("final_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave arbiter on the core's request/grant data bus. Sits directly downstream of the load/store unit (master 1) and the instruction fetch unit (master 0), and multiplexes their transfers onto the single slave-side bus. Responses are registered. It uses round-robin priority and a watchdog timeout that returns an error response if the slave never acknowledges.

## Interface
Parameters:
- TIMEOUT, 16: maximum BUSY cycles without slave ACK before abort; ≥2.

Ports:
- i_CLK  in  1  single clock, all state on rising edge
- i_RST_N  in  1  asynchronous, active-low reset
- i_Mx_WDATA  in  32  write data, x∈{0,1}
- i_Mx_ADDR  in  32  byte address
- i_Mx_WE  in  1  write enable
- i_Mx_RE  in  1  read enable
- i_Mx_HB  in  2  size: 00 byte, 01 half, 10 word
- i_Mx_REQ  in  1  transfer request; held with payload until GNT
- o_Mx_RDATA  out  32  registered read data of last completed transfer
- o_Mx_GNT  out  1  one-cycle completion pulse
- o_Mx_ERR  out  1  one-cycle pulse with GNT on timeout
- o_S_WDATA / o_S_ADDR / o_S_HB  out  32/32/2  owner payload
- o_S_WE / o_S_RE / o_S_REQ  out  1 each  owner strobes / slave request
- i_S_RDATA  in  32  slave read data, valid with ACK
- i_S_ACK  in  1  slave completion, single cycle

## Operation
- State registers: state ∈ {IDLE, BUSY, RESP}; owner (1 bit); last (1 bit, master most recently granted); timeout counter, $clog2(TIMEOUT+1) bits.
- IDLE: if any i_Mx_REQ, pick owner (only requester; if both, the master ≠ last), clear counter, go BUSY. Otherwise stay.
- BUSY: o_S_REQ=1; o_S_* payload/strobes = owner's inputs (combinational mux on registered owner).
  - i_S_ACK=1: capture i_S_RDATA into owner's RDATA register (reads and writes alike); ERR=0; last←owner; go RESP.
  - No ACK: counter+1; when counter reaches TIMEOUT-1 (i.e. TIMEOUT-th BUSY cycle) with no ACK: owner's RDATA←0, set error flag, last←owner, go RESP.
  - ACK in the same cycle as expiry: ACK wins, normal completion, ERR=0.
- RESP: o_Mx_GNT=1 for owner only, o_Mx_ERR=error flag; o_S_REQ=0; requests ignored; go IDLE.
- o_S_* outside BUSY: all zero (REQ, WE, RE, ADDR, WDATA, HB).
- Non-owner RDATA register never changes; each holds value until its own next completion.
- ACK received in IDLE/RESP: ignored.
- Owner dropping REQ in BUSY (protocol violation): transfer still completes; GNT still pulsed.
- Reset (async, any state): state IDLE, owner 0, last 1 (M0 preferred first), counter 0, error flag 0, both RDATA 0, all outputs 0 immediately. An in-flight transfer is abandoned without GNT.

## Timing
- Cycle n: REQ sampled high at edge n in IDLE → BUSY from n; o_S_REQ high in cycle n.
- Earliest ACK in cycle n → RESP, GNT high in cycle n+1, IDLE at n+2.
- Min REQ-to-GNT: 1 cycle after the first BUSY cycle; min back-to-back period per master: 3 cycles.
- Timeout: o_S_REQ high exactly TIMEOUT cycles, GNT+ERR in the following cycle.
- Master must keep REQ high through the GNT cycle and may change payload from the next cycle.
- GNT and RDATA become valid together; RDATA is stable from GNT onward.

## Test plan
- M1 read 0x100, HB=10, slave ACK in first BUSY cycle with 0xCAFEBABE → o_M1_GNT single pulse in 2nd cycle after REQ edge, o_M1_RDATA=0xCAFEBABE, ERR=0, M0 outputs unchanged.
- Both REQ high from reset, slave always ACKs after 1 cycle → grant order M0, M1, M0, M1; both REQs held → strict alternation.
- M1 write, WE=1, HB=01, ADDR 0x202, WDATA 0x00001234 → o_S_* match exactly during BUSY and are zero in IDLE/RESP; GNT pulsed.
- TIMEOUT=16, no ACK on M0 read → o_S_REQ high 16 cycles, then o_M0_GNT=o_M0_ERR=1 for one cycle, o_M0_RDATA=0. A late ACK in the next cycle has no effect.
- ACK on the 16th BUSY cycle with 0x55AA55AA → normal completion, ERR=0, RDATA=0x55AA55AA.
- i_RST_N low mid-BUSY → all outputs 0 asynchronously, no GNT. After release with M1 REQ still high → M1 served normally.
